// File: rtl/jpeg_byte_feeder_pkg.sv
// Shared types and marker constants for the JPEG byte feeder.
// Marker bytes used by the optional JPEG_BYTE_FEEDER_MARKER_CHK_EN checker.
package jpeg_byte_feeder_pkg;

  localparam logic [7:0] SOI_B1 = 8'hFF;
  localparam logic [7:0] SOI_B2 = 8'hD8;
  localparam logic [7:0] EOI_B1 = 8'hFF;
  localparam logic [7:0] EOI_B2 = 8'hD9;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
    logic [1:0]  lidx;
    logic        last;
  } hold_t;

  function automatic logic [7:0] pick_byte(
    input logic [31:0] w,
    input logic [1:0]  i,
    input logic        be
  );
    logic [1:0] k;
    k = be ? (2'd3 - i) : i;
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/jpeg_byte_feeder.sv
// Word-to-byte serialiser framing JPEG files for the decoder input port.
// Define JPEG_BYTE_FEEDER_MARKER_CHK_EN to enable SOI/EOI marker checking.
module jpeg_byte_feeder
  import jpeg_byte_feeder_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wi_valid,
  input  logic [31:0]      wi_data,
  input  logic             wi_last,
  input  logic [1:0]       wi_nbytes,
  output logic             wo_ready,
  output logic             ao_we,
  output logic             ao_begin,
  output logic             ao_end,
  output logic [7:0]       ao_data,
  input  logic             ai_next,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             err
);

  hold_t      hold;
  logic       hv;
  logic       first_pending;
  logic       at_last;
  logic       xfer;
  logic       accept;
  logic [7:0] byte_sel;

  assign at_last  = hold.idx == hold.lidx;
  assign xfer     = hv & ai_next;
  assign byte_sel = pick_byte(hold.data, hold.idx, BIG_ENDIAN);

  assign ao_we    = hv;
  assign ao_data  = hv ? byte_sel : 8'h00;
  assign ao_begin = hv & first_pending & (hold.idx == 2'd0);
  assign ao_end   = hv & hold.last & at_last;

  // Reload while the last byte leaves keeps one byte per clock.
  assign wo_ready = rst & (~hv | (xfer & at_last));
  assign accept   = wi_valid & wo_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold          <= '0;
      hv            <= 1'b0;
      first_pending <= 1'b1;
      busy          <= 1'b0;
      byte_cnt      <= '0;
    end else begin
      if (accept) begin
        hv         <= 1'b1;
        hold.data  <= wi_data;
        hold.idx   <= 2'd0;
        hold.lidx  <= wi_last ? (wi_nbytes - 2'd1) : 2'd3;
        hold.last  <= wi_last;
      end else if (xfer) begin
        if (at_last) hv <= 1'b0;
        else hold.idx <= hold.idx + 2'd1;
      end
      if (xfer) begin
        first_pending <= ao_end;
        if (ao_end) busy <= 1'b0;
        else if (ao_begin) busy <= 1'b1;
        if (ao_begin) byte_cnt <= CNT_W'(1);
        else if (~&byte_cnt) byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

`ifdef JPEG_BYTE_FEEDER_MARKER_CHK_EN
  logic [7:0] prev_byte;
  logic       second;

  assign second = ~ao_begin & (byte_cnt == CNT_W'(1));

  // A file of one byte can never carry both markers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err       <= 1'b0;
      prev_byte <= 8'h00;
    end else if (xfer) begin
      prev_byte <= ao_data;
      if (ao_begin) begin
        err <= (ao_data != SOI_B1) | ao_end;
      end else begin
        err <= err
             | (second & (ao_data != SOI_B2))
             | (ao_end & ((prev_byte != EOI_B1)
                        | (ao_data != EOI_B2)));
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_byte_feeder.sv
// Randomised self-checking bench for jpeg_byte_feeder.
// Runs a big-endian and a little-endian instance on shared inputs.
module tb_jpeg_byte_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wi_valid = 1'b0;
  logic [31:0] wi_data = '0;
  logic        wi_last = 1'b0;
  logic [1:0]  wi_nbytes = '0;
  logic        ai_next = 1'b0;

  logic        be_ready, be_we, be_beg, be_end, be_busy, be_err;
  logic [7:0]  be_data;
  logic [23:0] be_cnt;
  logic        le_ready, le_we, le_beg, le_end, le_busy, le_err;
  logic [7:0]  le_data;
  logic [23:0] le_cnt;

  jpeg_byte_feeder #(.BIG_ENDIAN(1'b1), .CNT_W(24)) u_be (
    .clk(clk), .rst(rst),
    .wi_valid(wi_valid), .wi_data(wi_data),
    .wi_last(wi_last), .wi_nbytes(wi_nbytes),
    .wo_ready(be_ready), .ao_we(be_we),
    .ao_begin(be_beg), .ao_end(be_end),
    .ao_data(be_data), .ai_next(ai_next),
    .busy(be_busy), .byte_cnt(be_cnt), .err(be_err)
  );

  jpeg_byte_feeder #(.BIG_ENDIAN(1'b0), .CNT_W(24)) u_le (
    .clk(clk), .rst(rst),
    .wi_valid(wi_valid), .wi_data(wi_data),
    .wi_last(wi_last), .wi_nbytes(wi_nbytes),
    .wo_ready(le_ready), .ao_we(le_we),
    .ao_begin(le_beg), .ao_end(le_end),
    .ao_data(le_data), .ai_next(ai_next),
    .busy(le_busy), .byte_cnt(le_cnt), .err(le_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wptr = 0;
  int stab_bad = 0;

  logic [31:0] q_data[$];
  logic        q_last[$];
  logic [1:0]  q_nb[$];

  logic [7:0]  ob_be[$], ob_le[$];
  logic        ob_beg[$], ob_end[$];
  int          ob_cyc[$];

  logic [7:0]  exp_be[$], exp_le[$];
  logic        exp_beg[$], exp_end[$];
  int          exp_len;
  logic        exp_err_be, exp_err_le;

  function automatic logic marker_bad(input logic [7:0] f[$]);
`ifdef JPEG_BYTE_FEEDER_MARKER_CHK_EN
    int n;
    n = f.size();
    if (n < 2) return 1'b1;
    return f[0] != 8'hFF || f[1] != 8'hD8 ||
           f[n-2] != 8'hFF || f[n-1] != 8'hD9;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: expand queued words into per-file byte streams.
  task automatic model();
    logic [7:0] fb_be[$], fb_le[$];
    logic start;
    int n;
    exp_be.delete(); exp_le.delete();
    exp_beg.delete(); exp_end.delete();
    start = 1'b1;
    for (int i = 0; i < q_data.size(); i++) begin
      n = 4;
      if (q_last[i]) n = (q_nb[i] == 2'd0) ? 4 : int'(q_nb[i]);
      if (start) begin fb_be.delete(); fb_le.delete(); end
      for (int k = 0; k < n; k++) begin
        exp_be.push_back(q_data[i][8*(3-k) +: 8]);
        exp_le.push_back(q_data[i][8*k +: 8]);
        exp_beg.push_back(start && k == 0);
        exp_end.push_back(q_last[i] && k == n - 1);
        fb_be.push_back(q_data[i][8*(3-k) +: 8]);
        fb_le.push_back(q_data[i][8*k +: 8]);
      end
      start = q_last[i];
    end
    exp_len = fb_be.size();
    exp_err_be = marker_bad(fb_be);
    exp_err_le = marker_bad(fb_le);
  endtask

  task automatic clear_all();
    q_data.delete(); q_last.delete(); q_nb.delete();
    ob_be.delete(); ob_le.delete();
    ob_beg.delete(); ob_end.delete(); ob_cyc.delete();
    wptr = 0;
    stab_bad = 0;
  endtask

  task automatic add_word(input logic [31:0] d,
                          input logic l, input logic [1:0] nb);
    q_data.push_back(d); q_last.push_back(l); q_nb.push_back(nb);
  endtask

  // Packs a file's bytes big-endian into words.
  task automatic add_file(input logic [7:0] b[$]);
    int n, nw;
    logic [31:0] d;
    n = b.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int k = 0; k < 4; k++)
        if (4*w + k < n) d[8*(3-k) +: 8] = b[4*w + k];
      add_word(d, w == nw - 1, 2'(n % 4));
    end
  endtask

  // mode 0: always ready, 1: toggling, 2: random ready and valid
  task automatic play(input int mode, input int stop_after);
    int xf, budget;
    logic pstall, pb, pe, acc;
    logic [7:0] pd;
    xf = 0; budget = 0; pstall = 1'b0; pb = 0; pe = 0; pd = '0;
    while (1) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0: ai_next = 1'b1;
        1: ai_next = (cyc % 2 == 0);
        default: ai_next = ($urandom_range(0, 3) != 0);
      endcase
      if (wptr < q_data.size() &&
          !(mode == 2 && $urandom_range(0, 3) == 0)) begin
        wi_valid = 1'b1;
        wi_data = q_data[wptr];
        wi_last = q_last[wptr];
        wi_nbytes = q_nb[wptr];
      end else begin
        wi_valid = 1'b0;
        wi_data = $urandom;
        wi_last = 1'($urandom);
        wi_nbytes = 2'($urandom);
      end
      #1;
      if (pstall && (!be_we || be_data !== pd ||
                     be_beg !== pb || be_end !== pe))
        stab_bad++;
      pstall = be_we & ~ai_next;
      pd = be_data; pb = be_beg; pe = be_end;
      if (be_we && ai_next) begin
        ob_be.push_back(be_data);
        ob_le.push_back(le_data);
        ob_beg.push_back(be_beg);
        ob_end.push_back(be_end);
        ob_cyc.push_back(cyc);
        xf++;
      end
      acc = wi_valid && be_ready;
      if (acc) wptr++;
      if (stop_after > 0 && xf == stop_after) break;
      if (!acc && wptr >= q_data.size() && !be_we) break;
      budget++;
      if (budget > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL play_timeout wptr=%0d want %0d",
                 wptr, q_data.size());
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({be_we, be_beg, be_end, be_data, be_ready} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_out got we%b b%b e%b d%h r%b want 0",
               be_we, be_beg, be_end, be_data, be_ready);
    end
    n_cmp++;
    if ({be_busy, be_cnt, be_err} !== 26'h0) begin
      n_bad++;
      $display("FAIL reset_state got busy%b cnt%0d err%b want 0",
               be_busy, be_cnt, be_err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_spec_stream();
    clear_all();
    add_word(32'hFFD8E0AA, 1'b0, 2'd0);
    add_word(32'h1234FFD9, 1'b1, 2'd0);
    model();
    play(0, 0);
    n_cmp++;
    if (ob_be.size() != 8) begin
      n_bad++;
      $display("FAIL spec_count got %0d want 8", ob_be.size());
    end
    for (int i = 0; i < exp_be.size(); i++) begin
      n_cmp++;
      if (i >= ob_be.size() || ob_be[i] !== exp_be[i] ||
          ob_le[i] !== exp_le[i] || ob_beg[i] !== exp_beg[i] ||
          ob_end[i] !== exp_end[i]) begin
        n_bad++;
        $display("FAIL spec_byte %0d got %h/%h b%b e%b want %h/%h b%b e%b",
                 i, ob_be[i], ob_le[i], ob_beg[i], ob_end[i],
                 exp_be[i], exp_le[i], exp_beg[i], exp_end[i]);
      end
    end
    for (int i = 1; i < ob_cyc.size(); i++) begin
      n_cmp++;
      if (ob_cyc[i] - ob_cyc[i-1] != 1) begin
        n_bad++;
        $display("FAIL spec_gap at %0d got %0d want 1",
                 i, ob_cyc[i] - ob_cyc[i-1]);
      end
    end
    n_cmp++;
    if (be_cnt !== 24'(exp_len) || be_busy !== 1'b0 ||
        be_err !== exp_err_be || le_err !== exp_err_le) begin
      n_bad++;
      $display("FAIL spec_final got cnt%0d busy%b err%b/%b want %0d 0 %b/%b",
               be_cnt, be_busy, be_err, le_err,
               exp_len, exp_err_be, exp_err_le);
    end
  endtask

  task automatic test_stall();
    clear_all();
    add_word(32'hFFD8E0AA, 1'b0, 2'd0);
    add_word(32'h1234FFD9, 1'b1, 2'd0);
    model();
    play(1, 0);
    n_cmp++;
    if (ob_be.size() != exp_be.size() || stab_bad != 0) begin
      n_bad++;
      $display("FAIL stall_shape got n%0d unstable%0d want n%0d 0",
               ob_be.size(), stab_bad, exp_be.size());
    end
    for (int i = 0; i < exp_be.size(); i++) begin
      n_cmp++;
      if (i >= ob_be.size() || ob_be[i] !== exp_be[i] ||
          ob_beg[i] !== exp_beg[i] || ob_end[i] !== exp_end[i]) begin
        n_bad++;
        $display("FAIL stall_byte %0d got %h b%b e%b want %h b%b e%b",
                 i, ob_be[i], ob_beg[i], ob_end[i],
                 exp_be[i], exp_beg[i], exp_end[i]);
      end
    end
  endtask

  task automatic test_le_partial();
    clear_all();
    add_word(32'h44332211, 1'b1, 2'd3);
    model();
    play(0, 0);
    n_cmp++;
    if (ob_le.size() != 3) begin
      n_bad++;
      $display("FAIL le_count got %0d want 3", ob_le.size());
    end
    for (int i = 0; i < exp_le.size(); i++) begin
      n_cmp++;
      if (i >= ob_le.size() || ob_le[i] !== exp_le[i] ||
          ob_be[i] !== exp_be[i] || ob_end[i] !== exp_end[i]) begin
        n_bad++;
        $display("FAIL le_byte %0d got %h/%h e%b want %h/%h e%b",
                 i, ob_le[i], ob_be[i], ob_end[i],
                 exp_le[i], exp_be[i], exp_end[i]);
      end
    end
    n_cmp++;
    if (le_cnt !== 24'd3) begin
      n_bad++;
      $display("FAIL le_cnt got %0d want 3", le_cnt);
    end
  endtask

  task automatic test_single_byte();
    clear_all();
    add_word(32'h000000FF, 1'b1, 2'd1);
    model();
    play(0, 0);
    n_cmp++;
    if (ob_be.size() != 1 || ob_be[0] !== 8'h00 ||
        ob_le[0] !== 8'hFF || ob_beg[0] !== 1'b1 ||
        ob_end[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL single_byte got n%0d %h/%h b%b e%b want 1 00/ff b1 e1",
               ob_be.size(), ob_be[0], ob_le[0], ob_beg[0], ob_end[0]);
    end
    n_cmp++;
    if (be_busy !== 1'b0 || be_cnt !== 24'd1 ||
        be_err !== exp_err_be || le_err !== exp_err_le) begin
      n_bad++;
      $display("FAIL single_state got busy%b cnt%0d err%b/%b want 0 1 %b/%b",
               be_busy, be_cnt, be_err, le_err, exp_err_be, exp_err_le);
    end
  endtask

  task automatic test_reset_midfile();
    clear_all();
    add_word(32'hAABBCCDD, 1'b0, 2'd0);
    add_word(32'h11223344, 1'b1, 2'd0);
    play(0, 3);
    @(posedge clk);
    #2;
    n_cmp++;
    if (be_busy !== 1'b1 || be_cnt !== 24'd3) begin
      n_bad++;
      $display("FAIL mid_busy got busy%b cnt%0d want 1 3", be_busy, be_cnt);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({be_we, be_beg, be_end, be_data, be_ready,
         be_busy, be_cnt, be_err} !== 38'h0) begin
      n_bad++;
      $display("FAIL mid_reset got we%b d%h r%b busy%b cnt%0d want 0",
               be_we, be_data, be_ready, be_busy, be_cnt);
    end
    wi_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_all();
    add_word(32'hFFD8FFD9, 1'b1, 2'd0);
    model();
    play(0, 1);
    @(posedge clk);
    #1;
    n_cmp++;
    if (be_cnt !== 24'd1 || ob_beg[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_restart got cnt%0d b%b want 1 1", be_cnt, ob_beg[0]);
    end
    play(0, 0);
    for (int i = 0; i < exp_be.size(); i++) begin
      n_cmp++;
      if (i >= ob_be.size() || ob_be[i] !== exp_be[i] ||
          ob_beg[i] !== exp_beg[i] || ob_end[i] !== exp_end[i]) begin
        n_bad++;
        $display("FAIL mid_byte %0d got %h b%b e%b want %h b%b e%b",
                 i, ob_be[i], ob_beg[i], ob_end[i],
                 exp_be[i], exp_beg[i], exp_end[i]);
      end
    end
    n_cmp++;
    if (be_cnt !== 24'd4 || be_err !== exp_err_be) begin
      n_bad++;
      $display("FAIL mid_final got cnt%0d err%b want 4 %b",
               be_cnt, be_err, exp_err_be);
    end
  endtask

  task automatic test_random();
    logic [7:0] f[$];
    int n;
    for (int it = 0; it < 6; it++) begin
      clear_all();
      for (int fi = 0; fi < 3; fi++) begin
        n = $urandom_range(1, 13);
        f.delete();
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
        if (n >= 4 && $urandom_range(0, 1) == 1) begin
          f[0] = 8'hFF; f[1] = 8'hD8;
          f[n-2] = 8'hFF; f[n-1] = 8'hD9;
        end
        add_file(f);
      end
      model();
      play(2, 0);
      n_cmp++;
      if (ob_be.size() != exp_be.size() || stab_bad != 0) begin
        n_bad++;
        $display("FAIL rand%0d_shape got n%0d unstable%0d want n%0d 0",
                 it, ob_be.size(), stab_bad, exp_be.size());
      end
      for (int i = 0; i < exp_be.size(); i++) begin
        n_cmp++;
        if (i >= ob_be.size() || ob_be[i] !== exp_be[i] ||
            ob_le[i] !== exp_le[i] || ob_beg[i] !== exp_beg[i] ||
            ob_end[i] !== exp_end[i]) begin
          n_bad++;
          $display("FAIL rand%0d_byte %0d got %h/%h b%b e%b want %h/%h b%b e%b",
                   it, i, ob_be[i], ob_le[i], ob_beg[i], ob_end[i],
                   exp_be[i], exp_le[i], exp_beg[i], exp_end[i]);
        end
      end
      n_cmp++;
      if (be_cnt !== 24'(exp_len) || be_busy !== 1'b0 ||
          be_err !== exp_err_be || le_err !== exp_err_le) begin
        n_bad++;
        $display("FAIL rand%0d_final got cnt%0d busy%b err%b/%b want %0d 0 %b/%b",
                 it, be_cnt, be_busy, be_err, le_err,
                 exp_len, exp_err_be, exp_err_le);
      end
    end
  endtask

  task automatic test_marker();
    logic [7:0] f[$];
    clear_all();
    f = '{8'hFF, 8'hD8, 8'h11, 8'hFF, 8'hD8};
    add_file(f);
    model();
    play(0, 0);
    n_cmp++;
    if (be_err !== exp_err_be || ob_be.size() != 5) begin
      n_bad++;
      $display("FAIL marker_bad_eoi got err%b n%0d want %b 5",
               be_err, ob_be.size(), exp_err_be);
    end
    clear_all();
    f = '{8'hFF, 8'hD8, 8'h22, 8'h33, 8'hFF, 8'hD9};
    add_file(f);
    model();
    play(0, 1);
    @(posedge clk);
    #1;
    n_cmp++;
    if (be_err !== 1'b0 || be_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL marker_clear got err%b busy%b want 0 1",
               be_err, be_busy);
    end
    play(0, 0);
    n_cmp++;
    if (be_err !== exp_err_be || be_cnt !== 24'd6) begin
      n_bad++;
      $display("FAIL marker_good got err%b cnt%0d want %b 6",
               be_err, be_cnt, exp_err_be);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_stream();
    test_stall();
    test_le_partial();
    test_single_byte();
    test_reset_midfile();
    test_marker();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
